// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment display driver:
//   - glyph codes: 0..9 are decimal digits, GLYPH_MINUS draws '-',
//     GLYPH_BLANK turns every segment off
//   - converter FSM state encoding
//   - active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   - add3_nibble: one shift-add-3 correction step for a BCD nibble
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [3:0] GLYPH_MINUS = 4'hA;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // A nibble of 5 or more would exceed 9 after the next doubling, so it is
  // pre-corrected by 3 so that the doubling carries into the next nibble.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// ---------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational glyph to segment decoder. Output is active-high; the
// board polarity is applied by the instantiating module.
// Ports:
//   glyph  in  4  glyph code (0..9, GLYPH_MINUS, GLYPH_BLANK)
//   seg_hi out 7  segments {g,f,e,d,c,b,a}, 1 = lit
// Unused codes decode to a blank digit.
// ---------------------------------------------------------------------------
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg_hi
);

  // Plain lookup from glyph code to lit segments; anything that is not a
  // digit or the minus sign shows nothing.
  always_comb begin
    case (glyph)
      4'd0:        seg_hi = SEG_0;
      4'd1:        seg_hi = SEG_1;
      4'd2:        seg_hi = SEG_2;
      4'd3:        seg_hi = SEG_3;
      4'd4:        seg_hi = SEG_4;
      4'd5:        seg_hi = SEG_5;
      4'd6:        seg_hi = SEG_6;
      4'd7:        seg_hi = SEG_7;
      4'd8:        seg_hi = SEG_8;
      4'd9:        seg_hi = SEG_9;
      GLYPH_MINUS: seg_hi = SEG_MINUS;
      default:     seg_hi = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display_gen.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_gen
// N-digit multiplexed seven-segment driver. A value arrives over a
// valid/ready handshake, is converted to BCD one bit per clock
// (shift-add-3), then committed to display registers that a prescaled
// scanner shows one digit at a time.
// Ports:
//   clk       in   1       system clock
//   rst_n     in   1       asynchronous active-low reset
//   in_valid  in   1       in_data valid
//   in_ready  out  1       converter idle, can accept
//   in_data   in   DATA_W  value to display
//   blank_lz  in   1       1: blank leading zeros (ones digit always shown)
//   disp_en   in   1       0: all anodes inactive, everything else keeps running
//   busy      out  1       conversion in progress
//   overflow  out  1       committed value did not fit in DIGITS digits
//   seg       out  7       segments {g,f,e,d,c,b,a}
//   dp        out  1       decimal point, always inactive
//   an        out  DIGITS  one-hot digit enable, an[0] = ones digit
// ---------------------------------------------------------------------------
module seg7_scan_display_gen
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int SIGNED_EN   = 0,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              blank_lz,
  input  logic              disp_en,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = (DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic                rst_int_n;
  logic [1:0]          rst_sync;
  conv_state_t         state;
  logic [DATA_W-1:0]   shift_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic                neg_q;
  logic                ovf_q;
  logic [DATA_W-1:0]   in_mag;
  logic                in_neg;
  logic [DIGITS*4-1:0] disp_bcd;
  logic                disp_neg;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    msd_idx;
  logic [3:0]          cur_nib;
  logic [3:0]          glyph;
  logic [6:0]          seg_hi;
  logic [DIGITS-1:0]   an_hot;

  // Reset asserts asynchronously but is released on a clock edge, so no
  // flop in the design sees reset removal near its active edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  // In signed mode the converter works on the magnitude and remembers the
  // sign separately; the most negative value maps to 2^(DATA_W-1), which
  // still fits as an unsigned DATA_W-bit number.
  always_comb begin
    in_neg = (SIGNED_EN != 0) && in_data[DATA_W-1];
    in_mag = in_neg ? (~in_data + 1'b1) : in_data;
  end

  // One shift-add-3 step: correct every nibble, including the spare top
  // nibble, then shift the next magnitude bit in at the bottom.
  for (genvar i = 0; i < DIGITS + 1; i++) begin : g_add3
    assign bcd_adj[i*4 +: 4] = add3_nibble(bcd_q[i*4 +: 4]);
  end

  assign bcd_next = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};

  // Converter FSM. IDLE accepts a value, CONV runs one bit per clock for
  // DATA_W clocks, COMMIT copies the result into the display registers in
  // a single step so the scanner never shows a half-converted value.
  // Overflow covers bits lost off the top, a non-zero spare nibble, and a
  // negative value whose magnitude leaves no digit free for the sign.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      shift_q  <= '0;
      bcd_q    <= '0;
      bit_cnt  <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            shift_q  <= in_mag;
            neg_q    <= in_neg;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_q   <= bcd_next;
          shift_q <= shift_q << 1;
          ovf_q   <= ovf_q | bcd_adj[BCD_W-1];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_bcd <= bcd_q[DIGITS*4-1:0];
          disp_neg <= neg_q;
          overflow <= ovf_q | (bcd_q[BCD_W-1 -: 4] != 4'd0)
                      | (neg_q & (bcd_q[DIGITS*4-1 -: 4] != 4'd0));
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Position of the most significant non-zero digit (0 when the value is
  // zero), used both for leading-zero blanking and to place the sign.
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_bcd[i*4 +: 4] != 4'd0) begin
        msd_idx = IDX_W'(i);
      end
    end
  end

  // Glyph for the digit currently being scanned. Overflow overrides
  // everything with dashes. With blanking on, the sign sits just left of
  // the leading digit; with blanking off it takes the leftmost position.
  always_comb begin
    cur_nib = disp_bcd[scan_idx*4 +: 4];
    glyph   = cur_nib;
    if (overflow) begin
      glyph = GLYPH_MINUS;
    end else if (blank_lz) begin
      if (scan_idx > msd_idx) begin
        glyph = (disp_neg && (scan_idx == msd_idx + 1'b1)) ? GLYPH_MINUS : GLYPH_BLANK;
      end
    end else if (disp_neg && (scan_idx == IDX_W'(DIGITS - 1))) begin
      glyph = GLYPH_MINUS;
    end
  end

  seg7_glyph_decode u_glyph_decode (
    .glyph  (glyph),
    .seg_hi (seg_hi)
  );

  // Digit slot timer: each digit stays lit for REFRESH_DIV clocks, then
  // the scan index moves one place left, wrapping back to the ones digit.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign an_hot = DIGITS'(1) << scan_idx;

  // Segments and anodes are registered from the same scan index on the
  // same edge, so a digit change never shows one digit's pattern on
  // another digit's anode. disp_en only gates the anodes.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= (SEG_ACT_LOW != 0) ? ~seg_hi : seg_hi;
      an  <= disp_en ? ((AN_ACT_LOW != 0) ? ~an_hot : an_hot) : AN_OFF;
    end
  end

  assign dp = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;

endmodule
